alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter N, default 4, datapath and register width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port cmd_valid  input  1  command present.
REQ-005 SHALL have port cmd_ready  output  1  command accepted when high with cmd_valid at a rising edge.
REQ-006 SHALL have port cmd_op  input  4  ALU control code, same encoding as the team ALU (bit3 logic/arith, bits2:1 y-select, bit0 cin).
REQ-007 SHALL have ports cmd_rd, cmd_ra, cmd_rb  input  2 each  destination, operand A, operand B register indices.
REQ-008 SHALL have port cmd_ld  input  1  load-immediate command, bypasses ALU.
REQ-009 SHALL have port cmd_imm  input  N  immediate value for cmd_ld.
REQ-010 SHALL have port cmd_rep  input  2  operation repeats rep+1 times.
REQ-011 SHALL have port cmd_cond  input  2  execution condition (used only with ALU_SEQ_COND_EN).
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-014 SHALL have ports rsp_data  output  N  and rsp_flags  output  4  result and {V,N,Z,C}.
REQ-015 SHALL have port rsp_skip  output  1  command suppressed by condition.
REQ-016 SHALL have ports dbg_sel  input  2  and dbg_data  output  N  combinational register-file read.

Function
REQ-017 SHALL hold four N-bit registers R0..R3 and a 4-bit flag register F={V,N,Z,C}.
REQ-018 SHALL implement FSM states IDLE, READ, EXEC, WB; cmd_ready=1 only in IDLE.
REQ-019 SHALL, on accept of a non-ld command at edge k, go IDLE->READ; READ latches A=R[ra], B=R[rb], count=rep, ->EXEC at edge k+1.
REQ-020 SHALL, in each EXEC cycle, drive the ALU with A, B, cmd_op and set A<=Result; if count=0 go to WB, else count<=count-1.
REQ-021 SHALL, on the edge leaving the final EXEC, write R[rd]<=Result and F<=flags of that final iteration; rsp_valid visible after edge k+2+rep.
REQ-022 SHALL, on accept with cmd_ld=1, write R[rd]<=cmd_imm at that edge, leave F unchanged, go to WB; rsp_data=cmd_imm.
REQ-023 SHALL hold rsp_valid, rsp_data, rsp_flags, rsp_skip stable in WB until rsp_ready=1; WB->IDLE on that edge.
REQ-024 SHALL ignore cmd_valid outside IDLE; no command is lost or duplicated.
REQ-025 SHALL latch all cmd_* fields at accept; later input changes have no effect.
REQ-026 SHALL wrap arithmetic modulo 2^N across repeats; ra=rb=rd aliasing uses values latched in READ.

Reset
REQ-027 SHALL, on reset asserted at any time including mid-operation, immediately force state IDLE, R0..R3=0, F=0, rsp_valid=0, rsp_data=0, rsp_flags=0, rsp_skip=0, count=0; cmd_ready=1 after release.

Configuration
REQ-028 SHALL, with ALU_SEQ_COND_EN defined, evaluate cmd_cond against F at accept: 00 always, 01 Z=1, 10 N=1, 11 C=1; false -> no register/flag write, go straight to WB with rsp_skip=1, rsp_data=R[rd], rsp_flags=F.
REQ-029 SHALL, without ALU_SEQ_COND_EN, ignore cmd_cond and tie rsp_skip to 0.

Structure
REQ-030 SHALL place the FSM state enum, flag bit index constants, and named ALU control codes (ADD=0010, SUB=0101, AND=1000, OR=1010, XOR=1100, NOT=1110) in package alu_seq_pkg.
REQ-031 SHALL instantiate the team ALU (ALU_G, N passed through) as its single sub-module; no other arithmetic in this block.

Verification (N=4)
REQ-032 SHALL check reset: after release R0..R3=0, F=0, cmd_ready=1, rsp_valid=0, dbg_data=0 for all dbg_sel.
REQ-033 SHALL check ld R1=3, R2=5, then ADD rd=3 ra=1 rb=2 rep=0 -> rsp_data=8, rsp_flags=1100, rsp_valid 2 cycles after accept, R3=8.
REQ-034 SHALL check SUB rd=0 ra=1 rb=1 -> rsp_data=0, rsp_flags=0011.
REQ-035 SHALL check ADD ra=1(3) rb=2(5) rep=2 -> rsp_data=2 (18 mod 16), C=1, rsp_valid 4 cycles after accept.
REQ-036 SHALL check rsp_ready=0 for 5 cycles with cmd_valid=1 -> outputs stable, cmd_ready=0, extra command not accepted; reset asserted in EXEC -> IDLE, all zero, no write.
REQ-037 SHALL check, with ALU_SEQ_COND_EN, cond=01 while Z=0 -> rsp_skip=1, R[rd] and F unchanged.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Brief    : Shared types and constants for the ALU sequencer: FSM state
//             encoding, flag bit positions, named ALU control codes and the
//             condition evaluation helper. Optional condition feature is
//             enabled in the top by defining ALU_SEQ_COND_EN.
//  Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        EXEC = 2'd2,
        WB   = 2'd3
    } state_t;

    // Bit positions inside the {V,N,Z,C} flag vector
    localparam int c_flag_c = 0;
    localparam int c_flag_z = 1;
    localparam int c_flag_n = 2;
    localparam int c_flag_v = 3;

    // ALU control codes: bit3 logic/arith, bits2:1 y-select, bit0 carry-in
    localparam logic [3:0] c_op_add = 4'b0010;
    localparam logic [3:0] c_op_sub = 4'b0101;
    localparam logic [3:0] c_op_and = 4'b1000;
    localparam logic [3:0] c_op_or  = 4'b1010;
    localparam logic [3:0] c_op_xor = 4'b1100;
    localparam logic [3:0] c_op_not = 4'b1110;

    // 00 always, 01 Z set, 10 N set, 11 C set
    function automatic logic cond_met(input logic [1:0] cond, input logic [3:0] flags);
        logic r;
        case (cond)
            2'b00:   r = 1'b1;
            2'b01:   r = flags[c_flag_z];
            2'b10:   r = flags[c_flag_n];
            default: r = flags[c_flag_c];
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_sequencer_alu.sv
`default_nettype none
// ============================================================================
//  Module   : ALU_G
//  Brief    : Team N-bit ALU. Arithmetic path computes A + Y + cin where Y is
//             selected from {0, B, ~B, all-ones}; logic path offers AND, OR,
//             XOR and NOT A. Flags are {V,N,Z,C}; V and C are zero for logic.
//  Revision : 1.0 - initial release
// ============================================================================
module ALU_G #(
    parameter int N = 4
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic [3:0]   i_ctrl,
    output logic [N-1:0] o_y,
    output logic [3:0]   o_flags
);

    logic [N-1:0] w_yop;
    logic [N:0]   w_sum;
    logic [N-1:0] w_logic;
    logic         w_carry;
    logic         w_ovf;

    // Result and flag generation for both arithmetic and logic modes
    always_comb begin
        w_yop   = '0;
        w_logic = '0;
        case (i_ctrl[2:1])
            2'b00:   w_yop = '0;
            2'b01:   w_yop = i_b;
            2'b10:   w_yop = ~i_b;
            default: w_yop = '1;
        endcase
        case (i_ctrl[2:1])
            2'b00:   w_logic = i_a & i_b;
            2'b01:   w_logic = i_a | i_b;
            2'b10:   w_logic = i_a ^ i_b;
            default: w_logic = ~i_a;
        endcase
        w_sum   = {1'b0, i_a} + {1'b0, w_yop} + {{N{1'b0}}, i_ctrl[0]};
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        if (i_ctrl[3]) begin
            o_y = w_logic;
        end else begin
            o_y     = w_sum[N-1:0];
            w_carry = w_sum[N];
            // Signed overflow: operands agree in sign, result does not
            w_ovf   = (i_a[N-1] == w_yop[N-1]) && (w_sum[N-1] != i_a[N-1]);
        end
        o_flags = {w_ovf, o_y[N-1], (o_y == '0), w_carry};
    end

endmodule
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Brief    : Four-register sequencer around the team ALU. Accepts one
//             command at a time (load-immediate or repeated ALU op), writes
//             the register file and flags, and holds a response until taken.
//             Define ALU_SEQ_COND_EN to enable conditional execution on F.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [3:0]   cmd_op,
    input  logic [1:0]   cmd_rd,
    input  logic [1:0]   cmd_ra,
    input  logic [1:0]   cmd_rb,
    input  logic         cmd_ld,
    input  logic [N-1:0] cmd_imm,
    input  logic [1:0]   cmd_rep,
    input  logic [1:0]   cmd_cond,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic [3:0]   rsp_flags,
    output logic         rsp_skip,
    input  logic [1:0]   dbg_sel,
    output logic [N-1:0] dbg_data
);

    state_t       r_state;
    state_t       w_next;
    logic [N-1:0] r_regs [4];
    logic [3:0]   r_flags;
    logic [3:0]   r_op;
    logic [1:0]   r_rd;
    logic [1:0]   r_ra;
    logic [1:0]   r_rb;
    logic [1:0]   r_rep;
    logic [N-1:0] r_a;
    logic [N-1:0] r_b;
    logic [1:0]   r_count;
    logic [N-1:0] r_rsp_data;
    logic [3:0]   r_rsp_flags;
    logic [N-1:0] w_alu_y;
    logic [3:0]   w_alu_f;
    logic         w_accept;
    logic         w_cond_ok;

`ifdef ALU_SEQ_COND_EN
    logic         r_skip;
    assign w_cond_ok = cond_met(cmd_cond, r_flags);
    assign rsp_skip  = r_skip;
`else
    logic         w_unused_cond;
    assign w_unused_cond = ^cmd_cond;
    assign w_cond_ok     = 1'b1;
    assign rsp_skip      = 1'b0;
`endif

    assign w_accept  = (r_state == IDLE) && cmd_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign dbg_data  = r_regs[dbg_sel];

    ALU_G #(.N(N)) u_alu (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_ctrl  (r_op),
        .o_y     (w_alu_y),
        .o_flags (w_alu_f)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Next-state and handshake outputs
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_ld || !w_cond_ok) w_next = WB;
                    else                      w_next = READ;
                end
            end
            READ: w_next = EXEC;
            EXEC: if (r_count == 2'd0) w_next = WB;
            WB: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Command latch, operand fetch, repeat loop and write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) r_regs[i] <= '0;
            r_flags     <= '0;
            r_op        <= '0;
            r_rd        <= '0;
            r_ra        <= '0;
            r_rb        <= '0;
            r_rep       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_count     <= '0;
            r_rsp_data  <= '0;
            r_rsp_flags <= '0;
`ifdef ALU_SEQ_COND_EN
            r_skip      <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_op  <= cmd_op;
                    r_rd  <= cmd_rd;
                    r_ra  <= cmd_ra;
                    r_rb  <= cmd_rb;
                    r_rep <= cmd_rep;
`ifdef ALU_SEQ_COND_EN
                    r_skip <= !w_cond_ok;
`endif
                    if (!w_cond_ok) begin
                        // Suppressed command reports current state untouched
                        r_rsp_data  <= r_regs[cmd_rd];
                        r_rsp_flags <= r_flags;
                    end else if (cmd_ld) begin
                        r_regs[cmd_rd] <= cmd_imm;
                        r_rsp_data     <= cmd_imm;
                        r_rsp_flags    <= r_flags;
                    end
                end
                READ: begin
                    // Operands captured once so aliasing with rd is harmless
                    r_a     <= r_regs[r_ra];
                    r_b     <= r_regs[r_rb];
                    r_count <= r_rep;
                end
                EXEC: begin
                    r_a <= w_alu_y;
                    if (r_count == 2'd0) begin
                        r_regs[r_rd] <= w_alu_y;
                        r_flags      <= w_alu_f;
                        r_rsp_data   <= w_alu_y;
                        r_rsp_flags  <= w_alu_f;
                    end else begin
                        r_count <= r_count - 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Brief    : Directed scoreboard bench for alu_sequencer (N=4). Expected
//             responses are queued at issue and checked by a monitor on each
//             response handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int N = 4;

    typedef struct packed {
        logic [N-1:0] data;
        logic [3:0]   flags;
        logic         skip;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [3:0]   cmd_op;
    logic [1:0]   cmd_rd, cmd_ra, cmd_rb;
    logic         cmd_ld;
    logic [N-1:0] cmd_imm;
    logic [1:0]   cmd_rep;
    logic [1:0]   cmd_cond;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic [3:0]   rsp_flags;
    logic         rsp_skip;
    logic [1:0]   dbg_sel;
    logic [N-1:0] dbg_data;

    int   checks   = 0;
    int   failures = 0;
    exp_t q[$];

    alu_sequencer #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_ra    (cmd_ra),
        .cmd_rb    (cmd_rb),
        .cmd_ld    (cmd_ld),
        .cmd_imm   (cmd_imm),
        .cmd_rep   (cmd_rep),
        .cmd_cond  (cmd_cond),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_flags (rsp_flags),
        .rsp_skip  (rsp_skip),
        .dbg_sel   (dbg_sel),
        .dbg_data  (dbg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_reg(input int idx, input int exp);
        dbg_sel = idx[1:0];
        #1;
        chk($sformatf("reg_R%0d", idx), int'(dbg_data), exp);
    endtask

    // Drive one command and return once it has been accepted (posedge + 1)
    task automatic send(input logic [3:0] op, input int rd, input int ra, input int rb,
                        input logic ld, input int imm, input int rep, input int cond);
        int n;
        cmd_op   = op;
        cmd_rd   = rd[1:0];
        cmd_ra   = ra[1:0];
        cmd_rb   = rb[1:0];
        cmd_ld   = ld;
        cmd_imm  = imm[N-1:0];
        cmd_rep  = rep[1:0];
        cmd_cond = cond[1:0];
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_imm   = '1;
        cmd_rd    = 2'd3;
    endtask

    task automatic wait_valid(output int cyc);
        cyc = 0;
        while (!rsp_valid && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        if (cyc >= 20) cyc = 99;
    endtask

    // Scoreboard monitor: compare on every response handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("rsp_data",  int'(rsp_data),  int'(e.data));
                    chk("rsp_flags", int'(rsp_flags), int'(e.flags));
                    chk("rsp_skip",  int'(rsp_skip),  int'(e.skip));
                end
            end
        end
    end

    initial begin
        int lat;
        exp_t e;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_ra = '0;
        cmd_rb = '0; cmd_ld = 1'b0; cmd_imm = '0; cmd_rep = '0; cmd_cond = '0;
        rsp_ready = 1'b1; dbg_sel = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // Reset state
        chk("rst_cmd_ready", int'(cmd_ready), 1);
        chk("rst_rsp_valid", int'(rsp_valid), 0);
        chk("rst_rsp_data",  int'(rsp_data),  0);
        chk("rst_rsp_flags", int'(rsp_flags), 0);
        for (int i = 0; i < 4; i++) chk_reg(i, 0);

        // Load R1=3, R2=5
        e = '{data: 4'd3, flags: 4'b0000, skip: 1'b0}; q.push_back(e);
        send(c_op_add, 1, 0, 0, 1'b1, 3, 0, 0);
        wait_valid(lat); chk("ld_latency", lat, 0);
        e = '{data: 4'd5, flags: 4'b0000, skip: 1'b0}; q.push_back(e);
        send(c_op_add, 2, 0, 0, 1'b1, 5, 0, 0);
        wait_valid(lat);

        // ADD R3 = R1 + R2 = 8 : V=1 N=1
        e = '{data: 4'd8, flags: 4'b1100, skip: 1'b0}; q.push_back(e);
        send(c_op_add, 3, 1, 2, 1'b0, 0, 0, 0);
        wait_valid(lat); chk("add_latency", lat, 2);
        @(posedge clk); #1;
        chk_reg(3, 8);

        // SUB R0 = R1 - R1 = 0 : Z=1 C=1
        e = '{data: 4'd0, flags: 4'b0011, skip: 1'b0}; q.push_back(e);
        send(c_op_sub, 0, 1, 1, 1'b0, 0, 0, 0);
        wait_valid(lat); chk("sub_latency", lat, 2);

        // ADD rep=2: 3+5+5+5 = 18 -> 2, last step 13+5 carries
        e = '{data: 4'd2, flags: 4'b0001, skip: 1'b0}; q.push_back(e);
        send(c_op_add, 0, 1, 2, 1'b0, 0, 2, 0);
        wait_valid(lat); chk("rep_latency", lat, 4);
        @(posedge clk); #1;
        chk_reg(0, 2);

        // Backpressure: XOR R2 = 3^5 = 6 held while a ld R3=15 is offered
        rsp_ready = 1'b0;
        e = '{data: 4'd6, flags: 4'b0000, skip: 1'b0}; q.push_back(e);
        send(c_op_xor, 2, 1, 2, 1'b0, 0, 0, 0);
        wait_valid(lat);
        cmd_op = c_op_add; cmd_rd = 2'd3; cmd_ld = 1'b1; cmd_imm = 4'd15; cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_cmd_ready", int'(cmd_ready), 0);
            chk("stall_rsp_valid", int'(rsp_valid), 1);
            chk("stall_rsp_data",  int'(rsp_data),  6);
            chk("stall_rsp_flags", int'(rsp_flags), 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk_reg(3, 8);
        chk_reg(2, 6);

        // NOT R1 = ~3 = 12 : N=1 (ra=rb=rd aliasing)
        e = '{data: 4'd12, flags: 4'b0100, skip: 1'b0}; q.push_back(e);
        send(c_op_not, 1, 1, 1, 1'b0, 0, 0, 0);
        wait_valid(lat);
        @(posedge clk); #1;
        chk_reg(1, 12);

        // cond=01 while Z=0: ADD R3 = R1 + R1
`ifdef ALU_SEQ_COND_EN
        e = '{data: 4'd8, flags: 4'b0100, skip: 1'b1}; q.push_back(e);
        send(c_op_add, 3, 1, 1, 1'b0, 0, 0, 1);
        wait_valid(lat); chk("skip_latency", lat, 0);
        @(posedge clk); #1;
        chk_reg(3, 8);
        // Flags must still read Z=0 N=1: a Z-conditional op is skipped again
        e = '{data: 4'd6, flags: 4'b0100, skip: 1'b1}; q.push_back(e);
        send(c_op_add, 2, 1, 1, 1'b0, 0, 0, 1);
        wait_valid(lat);
        @(posedge clk); #1;
        chk_reg(2, 6);
`else
        e = '{data: 4'd8, flags: 4'b0101, skip: 1'b0}; q.push_back(e);
        send(c_op_add, 3, 1, 1, 1'b0, 0, 0, 1);
        wait_valid(lat); chk("nocond_latency", lat, 2);
        @(posedge clk); #1;
        chk_reg(3, 8);
`endif

        // Reset in the middle of EXEC
        send(c_op_add, 2, 1, 1, 1'b0, 0, 3, 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_rsp_flags", int'(rsp_flags), 0);
        chk("mid_rst_rsp_data",  int'(rsp_data),  0);
        for (int i = 0; i < 4; i++) chk_reg(i, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_cmd_ready", int'(cmd_ready), 1);
        chk("post_rst_rsp_valid", int'(rsp_valid), 0);
        chk_reg(2, 0);

        chk("scoreboard_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
